// File: rtl/gigatron_video_pkg.sv
// Shared constants and helpers for the Gigatron video output path.
// Holds OUT register bit positions, default raster timing and the colour
// expansion function used by gigatron_video_out.
package gigatron_video_pkg;

  // OUT register layout: [1:0] R, [3:2] G, [5:4] B, [6] hsync_n, [7] vsync_n
  localparam int unsigned OUT_R_LSB = 0;
  localparam int unsigned OUT_G_LSB = 2;
  localparam int unsigned OUT_B_LSB = 4;
  localparam int unsigned OUT_HS    = 6;
  localparam int unsigned OUT_VS    = 7;

  // Raster counter widths
  localparam int unsigned HCNT_W = 8;
  localparam int unsigned VCNT_W = 10;

  // Default timing, in CPU cycles and scanlines
  localparam int unsigned DEF_LINE_LEN    = 200;
  localparam int unsigned DEF_FRAME_LINES = 525;
  localparam int unsigned DEF_H_START     = 36;
  localparam int unsigned DEF_H_ACTIVE    = 160;
  localparam int unsigned DEF_V_START     = 35;
  localparam int unsigned DEF_V_ACTIVE    = 480;
  localparam int unsigned DEF_LOCK_FRAMES = 2;

  // 2-bit channel to 4-bit by replication: 0->0, 1->5, 2->A, 3->F
  function automatic logic [3:0] expand2(input logic [1:0] c);
    return {c, c};
  endfunction

endpackage

// File: rtl/gigatron_video_lock.sv
// Timing-lock tracker for the recovered Gigatron raster.
// Ports:
//   clock, reset      system clock, async active-high reset
//   ce                CPU-cycle enable
//   hs_fall_i         hsync falling edge seen this cycle
//   vs_fall_i         vsync falling edge seen this cycle (only with hs_fall_i)
//   hcnt_i, vcnt_i    counter values before this cycle's update
//   locked_o          timing stable for LOCK_FRAMES consecutive frames
module gigatron_video_lock
  import gigatron_video_pkg::*;
#(
  parameter int unsigned LINE_LEN    = DEF_LINE_LEN,
  parameter int unsigned FRAME_LINES = DEF_FRAME_LINES,
  parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  input  logic              hs_fall_i,
  input  logic              vs_fall_i,
  input  logic [HCNT_W-1:0] hcnt_i,
  input  logic [VCNT_W-1:0] vcnt_i,
  output logic              locked_o
);

  localparam int unsigned GF_W = $clog2(LOCK_FRAMES + 1);

  logic [GF_W-1:0] gf_q, gf_d;
  logic            armed_q, armed_d;
  logic            err_c;

  // Error detection and good-frame accounting
  always_comb begin
    gf_d    = gf_q;
    armed_d = armed_q;
    err_c   = (hs_fall_i && (hcnt_i != HCNT_W'(LINE_LEN - 1))) ||
              (vs_fall_i && (vcnt_i != VCNT_W'(FRAME_LINES - 1)));
    if (err_c) begin
      // An erroring frame end still opens a new measurement window
      gf_d    = '0;
      armed_d = vs_fall_i;
    end else if (vs_fall_i) begin
      if (armed_q && (gf_q != GF_W'(LOCK_FRAMES))) begin
        gf_d = gf_q + GF_W'(1);
      end
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gf_q     <= '0;
      armed_q  <= 1'b0;
      locked_o <= 1'b0;
    end else if (ce) begin
      gf_q     <= gf_d;
      armed_q  <= armed_d;
      locked_o <= (gf_d == GF_W'(LOCK_FRAMES));
    end
  end

endmodule

// File: rtl/gigatron_video_out.sv
// Gigatron OUT register to VGA/HDMI-encoder video stream.
// Recovers raster position from software sync bits, expands 2-bit colour
// to 4-bit, blanks outside the visible window and tracks timing lock.
// Ports:
//   clock, reset        system clock, async active-high reset
//   ce                  one pulse per CPU cycle
//   out_i               OUT register {vs_n, hs_n, B, G, R}
//   vga_r/g/b           blanked 4-bit colour
//   hs_n, vs_n          delay-matched syncs
//   de, x, y            visible-area enable and pixel coordinates
//   frame_start         one-clock pulse at each detected frame start
//   locked              timing stable
module gigatron_video_out
  import gigatron_video_pkg::*;
#(
  parameter int unsigned LINE_LEN    = DEF_LINE_LEN,
  parameter int unsigned FRAME_LINES = DEF_FRAME_LINES,
  parameter int unsigned H_START     = DEF_H_START,
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned V_START     = DEF_V_START,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [7:0] out_i,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       hs_n,
  output logic       vs_n,
  output logic       de,
  output logic [7:0] x,
  output logic [8:0] y,
  output logic       frame_start,
  output logic       locked
);

  logic [7:0]        s1_q;
  logic              hs_prev_q;
  logic              vs_line_q;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic              hs_fall_c, vs_fall_c, de_c;

  // Sync edge detection, counter next-state and visible window for the
  // sample held in s1 (counters here describe that same sample)
  always_comb begin
    hs_fall_c = hs_prev_q & ~s1_q[OUT_HS];
    vs_fall_c = hs_fall_c & vs_line_q & ~s1_q[OUT_VS];

    hcnt_d = hcnt_q;
    if (hs_fall_c) begin
      hcnt_d = '0;
    end else if (hcnt_q != '1) begin
      hcnt_d = hcnt_q + HCNT_W'(1);
    end

    vcnt_d = vcnt_q;
    if (vs_fall_c) begin
      vcnt_d = '0;
    end else if (hs_fall_c && (vcnt_q != '1)) begin
      vcnt_d = vcnt_q + VCNT_W'(1);
    end

    de_c = (hcnt_d >= HCNT_W'(H_START)) && (hcnt_d < HCNT_W'(H_START + H_ACTIVE)) &&
           (vcnt_d >= VCNT_W'(V_START)) && (vcnt_d < VCNT_W'(V_START + V_ACTIVE));
  end

  // Stage 1 capture, raster counters and stage 2 output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q        <= 8'hC0;
      hs_prev_q   <= 1'b1;
      vs_line_q   <= 1'b1;
      hcnt_q      <= '1;
      vcnt_q      <= '1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      hs_n        <= 1'b1;
      vs_n        <= 1'b1;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      // frame_start is a single system-clock pulse regardless of ce
      frame_start <= 1'b0;
      if (ce) begin
        s1_q      <= out_i;
        hs_prev_q <= s1_q[OUT_HS];
        if (hs_fall_c) begin
          vs_line_q <= s1_q[OUT_VS];
        end
        hcnt_q      <= hcnt_d;
        vcnt_q      <= vcnt_d;
        frame_start <= vs_fall_c;
        vga_r       <= de_c ? expand2(s1_q[OUT_R_LSB +: 2]) : 4'h0;
        vga_g       <= de_c ? expand2(s1_q[OUT_G_LSB +: 2]) : 4'h0;
        vga_b       <= de_c ? expand2(s1_q[OUT_B_LSB +: 2]) : 4'h0;
        hs_n        <= s1_q[OUT_HS];
        vs_n        <= s1_q[OUT_VS];
        de          <= de_c;
        x           <= de_c ? (hcnt_d - HCNT_W'(H_START)) : 8'h00;
        y           <= de_c ? 9'(vcnt_d - VCNT_W'(V_START)) : 9'h000;
      end
    end
  end

  gigatron_video_lock #(
    .LINE_LEN    (LINE_LEN),
    .FRAME_LINES (FRAME_LINES),
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_lock (
    .clock     (clock),
    .reset     (reset),
    .ce        (ce),
    .hs_fall_i (hs_fall_c),
    .vs_fall_i (vs_fall_c),
    .hcnt_i    (hcnt_q),
    .vcnt_i    (vcnt_q),
    .locked_o  (locked)
  );

endmodule

// File: tb/tb_gigatron_video_out.sv
// Self-checking bench for gigatron_video_out: randomized colour data inside
// structured sync timing, checked every clock against a sample-history model.
// Vertical timing is shortened so several frames fit in a short run.
module tb_gigatron_video_out;
  import gigatron_video_pkg::*;

  localparam int unsigned TB_FRAME_LINES = 12;
  localparam int unsigned TB_V_START     = 2;
  localparam int unsigned TB_V_ACTIVE    = 8;
  localparam int unsigned HS_LEN         = 24;
  localparam int unsigned VS_LINES       = 2;
  localparam int unsigned BIG            = 100000;

  logic       clock = 1'b0;
  logic       reset;
  logic       ce;
  logic [7:0] out_i;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       hs_n, vs_n, de, frame_start, locked;
  logic [7:0] x;
  logic [8:0] y;

  always #5 clock = ~clock;

  gigatron_video_out #(
    .FRAME_LINES (TB_FRAME_LINES),
    .V_START     (TB_V_START),
    .V_ACTIVE    (TB_V_ACTIVE)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ce          (ce),
    .out_i       (out_i),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .hs_n        (hs_n),
    .vs_n        (vs_n),
    .de          (de),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .locked      (locked)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raster position as plain sample/line counts since syncs
  logic [7:0]  pend;
  bit          prev_hs, vs_line;
  int unsigned since_h, lines_v, nv, n_vsf;
  int unsigned e_r, e_g, e_b, e_x, e_y;
  bit          e_de, e_hs, e_vs, e_fs, e_lock;
  int unsigned fs_seen, de_cnt, gap_max;

  task automatic model_reset();
    pend    = 8'hC0;
    prev_hs = 1'b1;
    vs_line = 1'b1;
    since_h = BIG;
    lines_v = BIG;
    nv      = 0;
    e_r = 0; e_g = 0; e_b = 0; e_x = 0; e_y = 0;
    e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_lock = 0;
  endtask

  task automatic model_step(input logic [7:0] nxt);
    bit hsf, vsf, err;
    int unsigned hp, vp;
    hsf = prev_hs && !pend[6];
    vsf = hsf && vs_line && !pend[7];
    err = (hsf && since_h != DEF_LINE_LEN - 1) || (vsf && lines_v != TB_FRAME_LINES - 1);
    if (hsf) vs_line = pend[7];
    if (hsf) since_h = 0;
    else if (since_h < BIG) since_h++;
    if (vsf) lines_v = 0;
    else if (hsf && lines_v < BIG) lines_v++;
    // Lock: more than LOCK_FRAMES frame ends since the last error
    if (err) nv = 0;
    if (vsf) begin
      nv++;
      n_vsf++;
    end
    hp = (since_h > 255) ? 255 : since_h;
    vp = (lines_v > 1023) ? 1023 : lines_v;
    e_de = (hp >= DEF_H_START) && (hp < DEF_H_START + DEF_H_ACTIVE) &&
           (vp >= TB_V_START) && (vp < TB_V_START + TB_V_ACTIVE);
    e_r    = e_de ? 32'(pend[1:0]) * 5 : 0;
    e_g    = e_de ? 32'(pend[3:2]) * 5 : 0;
    e_b    = e_de ? 32'(pend[5:4]) * 5 : 0;
    e_x    = e_de ? hp - DEF_H_START : 0;
    e_y    = e_de ? vp - TB_V_START : 0;
    e_hs   = pend[6];
    e_vs   = pend[7];
    e_fs   = vsf;
    e_lock = (nv > DEF_LOCK_FRAMES);
    prev_hs = pend[6];
    pend    = nxt;
  endtask

  task automatic compare_all();
    check_eq("r", 32'(vga_r), e_r);
    check_eq("g", 32'(vga_g), e_g);
    check_eq("b", 32'(vga_b), e_b);
    check_eq("de", 32'(de), 32'(e_de));
    check_eq("x", 32'(x), e_x);
    check_eq("y", 32'(y), e_y);
    check_eq("hs_n", 32'(hs_n), 32'(e_hs));
    check_eq("vs_n", 32'(vs_n), 32'(e_vs));
    check_eq("frame_start", 32'(frame_start), 32'(e_fs));
    check_eq("locked", 32'(locked), 32'(e_lock));
  endtask

  // One system clock; inputs driven at negedge, outputs checked 1 after posedge
  task automatic tick(input bit do_ce, input logic [7:0] v);
    @(negedge clock);
    ce    = do_ce;
    out_i = v;
    @(posedge clock);
    if (do_ce) model_step(v);
    else e_fs = 1'b0;
    #1;
    if (frame_start) fs_seen++;
    if (do_ce && de) de_cnt++;
    compare_all();
  endtask

  task automatic send_sample(input logic [7:0] v);
    if (gap_max != 0) repeat ($urandom_range(gap_max, 3)) tick(1'b0, v);
    tick(1'b1, v);
  endtask

  task automatic send_line(input int unsigned len, input bit vs_low);
    logic [7:0] v;
    for (int unsigned i = 0; i < len; i++) begin
      v[5:0] = 6'($urandom);
      if (i == 10 || i == 60) v[5:0] = 6'h39;
      v[6] = (i >= HS_LEN);
      v[7] = !vs_low;
      send_sample(v);
      // Outputs now reflect sample i-1
      if (i == 11) begin
        check_eq("blank_39_r", 32'(vga_r), 0);
        check_eq("blank_39_b", 32'(vga_b), 0);
      end
      if (i == 61 && e_de) begin
        check_eq("vis_39_r", 32'(vga_r), 5);
        check_eq("vis_39_g", 32'(vga_g), 10);
        check_eq("vis_39_b", 32'(vga_b), 15);
      end
    end
  endtask

  task automatic send_frame(input int short_line);
    for (int l = 0; l < int'(TB_FRAME_LINES); l++) begin
      send_line((l == short_line) ? 199 : DEF_LINE_LEN, l < int'(VS_LINES));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned vsf0;
    gap_max = 0;
    fs_seen = 0;
    de_cnt  = 0;
    n_vsf   = 0;
    reset   = 1'b1;
    ce      = 1'b0;
    out_i   = 8'hC0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 compare_all();
    @(negedge clock);
    reset = 1'b0;

    // Some lines, then an asynchronous reset mid-line
    repeat (3) send_line(DEF_LINE_LEN, 1'b0);
    send_line(100, 1'b0);
    @(negedge clock);
    ce = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check_eq("rst_hs_n", 32'(hs_n), 1);
    check_eq("rst_vs_n", 32'(vs_n), 1);
    check_eq("rst_de", 32'(de), 0);
    @(negedge clock);
    reset = 1'b0;

    // No sync after reset: no visible area
    for (int i = 0; i < 30; i++) send_sample({2'b11, 6'($urandom)});
    check_eq("de_before_sync", 32'(de), 0);

    // Dense frames: lock after two complete frames following the first frame start
    send_frame(-1);
    send_frame(-1);
    check_eq("locked_after_f2", 32'(locked), 0);
    send_frame(-1);
    check_eq("locked_after_f3", 32'(locked), 1);
    fs_seen = 0;
    de_cnt  = 0;
    send_frame(-1);
    check_eq("de_count_frame", de_cnt, DEF_H_ACTIVE * TB_V_ACTIVE);
    check_eq("fs_per_frame", fs_seen, 1);

    // One short line drops lock; two further good frames restore it
    send_frame(5);
    check_eq("lock_lost", 32'(locked), 0);
    send_frame(-1);
    check_eq("lock_low_1", 32'(locked), 0);
    send_frame(-1);
    check_eq("lock_low_2", 32'(locked), 0);
    send_frame(-1);
    check_eq("lock_regained", 32'(locked), 1);

    // Sparse ce: same sample-level behaviour, frame_start one clock wide
    gap_max = 15;
    fs_seen = 0;
    vsf0    = n_vsf;
    send_frame(-1);
    send_line(DEF_LINE_LEN, 1'b1);
    check_eq("fs_pulses_gapped", fs_seen, 2);
    check_eq("fs_model_gapped", fs_seen, n_vsf - vsf0);
    check_eq("locked_gapped", 32'(locked), 1);

    @(negedge clock);
    ce = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gigatron_video_out.md
Name: gigatron_video_out

Overview:
- Downstream of the gigatron core. Consumes the 8-bit OUT register, which is written once per 6.25 MHz CPU cycle.
- Recovers the raster position from the software-generated sync bits and expands the 2-bit colour channels to 4-bit.
- Produces blanked RGB, sync, data-enable and pixel coordinates for a VGA/HDMI encoder, plus a `locked` flag once timing is stable.
- Runs on the fast system clock, gated by the CPU-cycle enable.

Parameters:
- LINE_LEN, 200, CPU cycles per scanline.
- FRAME_LINES, 525, scanlines per frame.
- H_START, 36, hcnt of first visible pixel.
- H_ACTIVE, 160, visible pixels per line.
- V_START, 35, vcnt of first visible line.
- V_ACTIVE, 480, visible lines per frame.
- LOCK_FRAMES, 2, consecutive good frames needed to assert `locked`.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  one-cycle pulse per gigatron CPU cycle (6.25 MHz rate)
- out_i  in  8  gigatron OUT register: [1:0] R, [3:2] G, [5:4] B, [6] hsync_n, [7] vsync_n
- vga_r  out  4  red, 0 when not de
- vga_g  out  4  green, 0 when not de
- vga_b  out  4  blue, 0 when not de
- hs_n  out  1  hsync, active-low, delay-matched
- vs_n  out  1  vsync, active-low, delay-matched
- de  out  1  visible-area enable
- x  out  8  pixel column 0..159 while de, else 0
- y  out  9  line 0..479 while de, else 0
- frame_start  out  1  single-clock pulse at the start of each detected frame
- locked  out  1  timing stable

Behaviour:
- State advances only on clock edges with ce=1. With ce=0, all registers hold, except frame_start, which is always cleared the clock after it pulses.
- Reset (async, any time, including mid-frame):
  - vga_r/g/b, de, x, y, frame_start, locked = 0; hs_n = vs_n = 1.
  - hcnt = 255, vcnt = 1023 (saturated, so de stays 0 until the first sync).
  - good_frames = 0; s1 = 8'hC0.
- Stage 1: s1 <= out_i on ce. Stage 2: output registers computed from s1 and the counters. Latency is exactly 2 ce from an out_i sample to the corresponding outputs.
- Horizontal counting:
  - hs_fall = s1[6]==0 and previous s1[6]==1.
  - On hs_fall, hcnt <= 0. Otherwise hcnt <= hcnt+1, saturating at 255.
- Vertical counting:
  - vs_line = s1[7] sampled at each hs_fall; vs_fall = vs_line 1->0 between consecutive hs_falls.
  - At hs_fall: vcnt <= 0 if vs_fall, else vcnt+1, saturating at 1023.
  - frame_start pulses on the ce where vcnt is reset.
- Visible area:
  - de = (H_START <= hcnt < H_START+H_ACTIVE) and (V_START <= vcnt < V_START+V_ACTIVE), computed on the current counters.
  - x = hcnt-H_START, y = vcnt-V_START; both forced to 0 when de=0.
- Colour expansion: each 2-bit channel c maps to {c,c}, so 0->0, 1->5, 2->A, 3->F. Outputs are 0 when de=0.
- Sync pass-through: hs_n/vs_n = s1[6]/s1[7], registered in stage 2 so they stay aligned with the colour outputs.
- Lock tracking:
  - Bad line: at hs_fall, previous hcnt != LINE_LEN-1. Bad frame: at vs_fall, previous vcnt != FRAME_LINES-1.
  - A bad line or bad frame sets good_frames <= 0 and locked <= 0 on the same ce.
  - The first vs_fall after reset or after an error only starts measurement and does not increment good_frames.
  - A good frame end (vs_fall with no error since the previous vs_fall) increments good_frames, saturating at LOCK_FRAMES.
  - locked <= (good_frames == LOCK_FRAMES).
  - If bad line and frame end occur on the same ce, the error wins.
- Edge cases:
  - Hsync held low forever: hcnt saturates at 255, de=0, and lock is lost at the next hs_fall.
  - Both sync bits falling on the same sample: handled as one hs_fall and one vs_fall.

Decomposition:
- Package gigatron_video_pkg holds:
  - OUT bit indices: OUT_HS=6, OUT_VS=7, and R/G/B slice positions.
  - Default timing constants.
  - A 2->4 colour-expand function.
- One sub-module, gigatron_video_lock: takes hs_fall, vs_fall, hcnt and vcnt; returns `locked`, containing the error and good_frames logic.

Test Plan:
- Reset check: assert reset mid-line -> all outputs at reset values immediately, hs_n=vs_n=1; after release, no de until an hs_fall.
- Single line: drive standard timing (hsync low for 24 ce, line 200 ce) -> de high for exactly 160 ce starting 2 ce after the 36th sample following hs_fall; x runs 0..159.
- Full frames: drive 525-line frames with vsync low 2 lines -> frame_start pulses once per frame; y runs 0..479; locked rises at the end of the 2nd complete frame after the first vs_fall.
- Colour expansion: OUT=0x39 on a visible pixel -> r=5, g=A, b=F; the same value during blanking -> r=g=b=0.
- Lock loss: one 199-ce line in a locked stream -> locked falls on that hs_fall; it re-asserts only after 2 further good frames.
- ce gaps: random ce duty (1 in 4 to 1 in 16) -> output sequence identical to the dense-ce run, and frame_start stays exactly one clock wide.
